// File: rtl/pc_unit.sv
// Fetch-stage program counter: sequential advance, trap/redirect priority, buffered redirect while held,
// and stall watchdog. Define PC_MISALIGN_CHK_EN to align loaded targets to STEP and flag misaligned ones.
module pc_unit #(
    parameter int              XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int              STEP         = 4,
    parameter int              MAX_STALL    = 0
) (
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_stall,
    input  logic            i_fetch_ready,
    input  logic            i_redirect,
    input  logic [XLEN-1:0] i_redirect_pc,
    input  logic            i_trap,
    input  logic [XLEN-1:0] i_trap_vec,
    output logic [XLEN-1:0] o_pc,
    output logic            o_redirected,
    output logic            o_pend,
    output logic [15:0]     o_stall_cnt,
    output logic            o_stall_timeout,
    output logic            o_misalign
);

    typedef enum logic {RUN, PEND} state_t;

    localparam logic [XLEN-1:0] STEP_W      = XLEN'(STEP);
    localparam logic [15:0]     MAX_STALL_W = 16'(MAX_STALL);

    state_t          state_reg, state_next;
    logic [XLEN-1:0] pc_reg, pc_next, pc_seq_next;
    logic [XLEN-1:0] pend_pc_reg, pend_pc_next;
    logic [XLEN-1:0] target, load_pc;
    logic            load;
    logic            hold;
    logic            redirected_reg;
    logic [15:0]     stall_cnt_reg, stall_cnt_next, stall_cnt_inc;
    logic            timeout_reg, timeout_next;

    assign hold = i_stall | ~i_fetch_ready;

`ifdef PC_MISALIGN_CHK_EN
    logic [XLEN-1:0] align_mask;
    logic            misalign_reg;

    // Low log2(STEP) address bits must be zero for an aligned target.
    genvar gi;
    generate
        for (gi = 0; gi < XLEN; gi++) begin : g_mask
            assign align_mask[gi] = (gi < $clog2(STEP));
        end
    endgenerate

    assign load_pc = target & ~align_mask;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            misalign_reg <= 1'b0;
        end else begin
            misalign_reg <= load & (|(target & align_mask));
        end
    end

    assign o_misalign = misalign_reg;
`else
    assign load_pc    = target;
    assign o_misalign = 1'b0;
`endif

    always_comb begin
        state_next   = state_reg;
        pend_pc_next = pend_pc_reg;
        pc_seq_next  = pc_reg;
        target       = '0;
        load         = 1'b0;
        if (i_trap) begin
            target       = i_trap_vec;
            load         = 1'b1;
            state_next   = RUN;
            pend_pc_next = '0;
        end else if (i_redirect && !hold) begin
            target       = i_redirect_pc;
            load         = 1'b1;
            state_next   = RUN;
            pend_pc_next = '0;
        end else if (i_redirect) begin
            // Newest redirect wins while fetch is held.
            pend_pc_next = i_redirect_pc;
            state_next   = PEND;
        end else if (state_reg == PEND && !hold) begin
            target       = pend_pc_reg;
            load         = 1'b1;
            state_next   = RUN;
            pend_pc_next = '0;
        end else if (!hold) begin
            pc_seq_next  = pc_reg + STEP_W;
        end
    end

    assign pc_next = load ? load_pc : pc_seq_next;

    assign stall_cnt_inc  = (stall_cnt_reg == 16'hFFFF) ? stall_cnt_reg : stall_cnt_reg + 16'd1;
    assign stall_cnt_next = hold ? stall_cnt_inc : 16'd0;
    // Fires only on the transition into MAX_STALL; saturation keeps it from re-firing.
    assign timeout_next   = hold && (MAX_STALL_W != 16'd0) &&
                            (stall_cnt_reg != MAX_STALL_W) && (stall_cnt_inc == MAX_STALL_W);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_reg      <= RUN;
            pc_reg         <= RESET_VECTOR;
            pend_pc_reg    <= '0;
            redirected_reg <= 1'b0;
            stall_cnt_reg  <= 16'd0;
            timeout_reg    <= 1'b0;
        end else begin
            state_reg      <= state_next;
            pc_reg         <= pc_next;
            pend_pc_reg    <= pend_pc_next;
            redirected_reg <= load;
            stall_cnt_reg  <= stall_cnt_next;
            timeout_reg    <= timeout_next;
        end
    end

    assign o_pc            = pc_reg;
    assign o_redirected    = redirected_reg;
    assign o_pend          = (state_reg == PEND);
    assign o_stall_cnt     = stall_cnt_reg;
    assign o_stall_timeout = timeout_reg;

endmodule

// File: tb/tb_pc_unit.sv
// Bench for pc_unit: directed vector table, async-reset sequence, then random traffic
// against a reference model of the fetch-address rules.
module tb_pc_unit;

    localparam int STEP      = 4;
    localparam int MAX_STALL = 3;
`ifdef PC_MISALIGN_CHK_EN
    localparam bit MIS_EN = 1'b1;
`else
    localparam bit MIS_EN = 1'b0;
`endif
    localparam logic [31:0] MIS_PC = MIS_EN ? 32'h100 : 32'h102;

    logic        clk;
    logic        rst;
    logic        stall, ready, redir, trap;
    logic [31:0] rpc, tvec;
    logic [31:0] pc;
    logic        redirected, pend, timeout, misalign;
    logic [15:0] stall_cnt;

    int tests  = 0;
    int failed = 0;

    pc_unit #(
        .XLEN(32), .RESET_VECTOR(32'h0), .STEP(STEP), .MAX_STALL(MAX_STALL)
    ) dut (
        .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_fetch_ready(ready),
        .i_redirect(redir), .i_redirect_pc(rpc), .i_trap(trap), .i_trap_vec(tvec),
        .o_pc(pc), .o_redirected(redirected), .o_pend(pend), .o_stall_cnt(stall_cnt),
        .o_stall_timeout(timeout), .o_misalign(misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        stall, ready, redir;
        logic [31:0] rpc;
        logic        trap;
        logic [31:0] tvec;
        logic [31:0] pc;
        logic        rd, pend;
        logic [15:0] cnt;
        logic        to, mis;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic s, input logic r, input logic rd_in, input logic [31:0] rp,
                       input logic t, input logic [31:0] tv, input logic [31:0] epc,
                       input logic erd, input logic epend, input logic [15:0] ecnt,
                       input logic eto, input logic emis);
        vec_t v;
        v.stall = s; v.ready = r; v.redir = rd_in; v.rpc = rp; v.trap = t; v.tvec = tv;
        v.pc = epc; v.rd = erd; v.pend = epend; v.cnt = ecnt; v.to = eto; v.mis = emis;
        vecs.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_all(input string tag, input logic [31:0] epc, input logic erd,
                             input logic epend, input logic [15:0] ecnt, input logic eto,
                             input logic emis);
        check({tag, " pc"},      pc,                epc);
        check({tag, " redir"},   {31'd0, redirected}, {31'd0, erd});
        check({tag, " pend"},    {31'd0, pend},     {31'd0, epend});
        check({tag, " cnt"},     {16'd0, stall_cnt}, {16'd0, ecnt});
        check({tag, " timeout"}, {31'd0, timeout},  {31'd0, eto});
        check({tag, " misalign"},{31'd0, misalign}, {31'd0, emis});
    endtask

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_pend_q[$];
    int          m_cnt;
    logic        m_rd, m_to, m_mis;

    task automatic m_load(input logic [31:0] t);
        m_rd = 1'b1;
        if (MIS_EN) begin
            m_mis = (t % STEP) != 0;
            m_pc  = t - (t % STEP);
        end else begin
            m_pc = t;
        end
    endtask

    task automatic model_edge(input logic s, input logic r, input logic rd_in,
                              input logic [31:0] rp, input logic t, input logic [31:0] tv);
        logic h;
        int   old_cnt;
        h = s || !r;
        m_rd = 1'b0;
        m_mis = 1'b0;
        if (t) begin
            m_load(tv);
            m_pend_q.delete();
        end else if (rd_in && !h) begin
            m_load(rp);
            m_pend_q.delete();
        end else if (rd_in) begin
            m_pend_q.delete();
            m_pend_q.push_back(rp);
        end else if (m_pend_q.size() != 0 && !h) begin
            m_load(m_pend_q[0]);
            m_pend_q.delete();
        end else if (!h) begin
            m_pc = m_pc + STEP;
        end
        old_cnt = m_cnt;
        m_cnt = h ? ((m_cnt >= 65535) ? 65535 : m_cnt + 1) : 0;
        m_to = (MAX_STALL != 0) && (m_cnt == MAX_STALL) && (old_cnt != MAX_STALL);
    endtask

    initial begin
        rst = 1'b1; stall = 1'b0; ready = 1'b1; redir = 1'b0; trap = 1'b0;
        rpc = 32'h0; tvec = 32'h0;

        //   stall rdy redir rpc           trap tvec     pc            rd pend cnt to mis
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h4,        0, 0, 0, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h8,        0, 0, 0, 0, 0);
        add(1, 1, 0, 32'h0,        0, 32'h0,  32'h8,        0, 0, 1, 0, 0);
        add(1, 1, 0, 32'h0,        0, 32'h0,  32'h8,        0, 0, 2, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'hC,        0, 0, 0, 0, 0);
        add(1, 1, 1, 32'h100,      0, 32'h0,  32'hC,        0, 1, 1, 0, 0);
        add(1, 1, 1, 32'h200,      0, 32'h0,  32'hC,        0, 1, 2, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h200,      1, 0, 0, 0, 0);
        add(1, 1, 1, 32'h300,      0, 32'h0,  32'h200,      0, 1, 1, 0, 0);
        add(1, 1, 1, 32'h300,      1, 32'h80, 32'h80,       1, 0, 2, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h84,       0, 0, 0, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,  32'h84,       0, 0, 1, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,  32'h84,       0, 0, 2, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,  32'h84,       0, 0, 3, 1, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,  32'h84,       0, 0, 4, 0, 0);
        add(0, 0, 0, 32'h0,        0, 32'h0,  32'h84,       0, 0, 5, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h88,       0, 0, 0, 0, 0);
        add(0, 1, 1, 32'h102,      0, 32'h0,  MIS_PC,       1, 0, 0, 0, MIS_EN);
        add(0, 1, 0, 32'h0,        0, 32'h0,  MIS_PC + 4,   0, 0, 0, 0, 0);
        add(0, 1, 1, 32'hFFFFFFFC, 0, 32'h0,  32'hFFFFFFFC, 1, 0, 0, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h0,        0, 0, 0, 0, 0);
        add(1, 1, 1, 32'h400,      0, 32'h0,  32'h0,        0, 1, 1, 0, 0);
        add(0, 1, 1, 32'h500,      0, 32'h0,  32'h500,      1, 0, 0, 0, 0);
        add(0, 1, 0, 32'h0,        0, 32'h0,  32'h504,      0, 0, 0, 0, 0);

        repeat (2) @(posedge clk);
        #4 rst = 1'b0;
        #1 check_all("reset", 32'h0, 0, 0, 16'd0, 0, 0);

        foreach (vecs[i]) begin
            stall = vecs[i].stall; ready = vecs[i].ready; redir = vecs[i].redir;
            rpc = vecs[i].rpc; trap = vecs[i].trap; tvec = vecs[i].tvec;
            @(posedge clk); #1;
            $display("[TB] vec %0d pc=%h redir=%0b pend=%0b cnt=%0d to=%0b mis=%0b",
                     i, pc, redirected, pend, stall_cnt, timeout, misalign);
            check_all($sformatf("vec%0d", i), vecs[i].pc, vecs[i].rd, vecs[i].pend,
                      vecs[i].cnt, vecs[i].to, vecs[i].mis);
        end

        // Asynchronous reset while a target is buffered drops it before the next edge.
        stall = 1'b1; redir = 1'b1; rpc = 32'h700; trap = 1'b0;
        @(posedge clk); #1;
        check("pend before reset", {31'd0, pend}, 32'd1);
        redir = 1'b0;
        #2 rst = 1'b1;
        #1 check_all("async reset", 32'h0, 0, 0, 16'd0, 0, 0);
        $display("[TB] async reset pc=%h pend=%0b", pc, pend);
        @(posedge clk); #1;
        rst = 1'b0; stall = 1'b0;
        @(posedge clk); #1;
        check_all("post reset", 32'h4, 0, 0, 16'd0, 0, 0);
        $display("[TB] post reset pc=%h pend=%0b", pc, pend);

        m_pc = 32'h4; m_pend_q.delete(); m_cnt = 0; m_rd = 0; m_to = 0; m_mis = 0;
        for (int n = 0; n < 400; n++) begin
            stall = ($urandom_range(0, 99) < 35);
            ready = ($urandom_range(0, 99) < 80);
            redir = ($urandom_range(0, 99) < 15);
            trap  = ($urandom_range(0, 99) < 5);
            rpc   = $urandom;
            tvec  = $urandom;
            if ($urandom_range(0, 1) == 0) rpc = rpc & 32'hFFFF_FFFC;
            if ($urandom_range(0, 3) != 0) tvec = tvec & 32'hFFFF_FFFC;
            model_edge(stall, ready, redir, rpc, trap, tvec);
            @(posedge clk); #1;
            $display("[TB] rnd %0d s=%0b r=%0b rd=%0b t=%0b pc=%h pend=%0b cnt=%0d to=%0b",
                     n, stall, ready, redir, trap, pc, pend, stall_cnt, timeout);
            check_all($sformatf("rnd%0d", n), m_pc, m_rd, m_pend_q.size() != 0,
                      16'(m_cnt), m_to, m_mis);
        end

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
